// File: rtl/timing_beat_gen_if.sv
// Signal bundle between the front panel / hardwired controller and the beat sequencer.
// The slave modport is the sequencer side; master drives the panel and controller inputs.
interface timing_beat_gen_if #(
    parameter int CNT_W = 8
);
    logic             qd;
    logic             step;
    logic             stop;
    logic             short;
    logic             long;
    logic             w1;
    logic             w2;
    logic             w3;
    logic             running;
    logic             cycle_end;
    logic [CNT_W-1:0] cycle_cnt;

    modport master (
        output qd, step, stop, short, long,
        input  w1, w2, w3, running, cycle_end, cycle_cnt
    );

    modport slave (
        input  qd, step, stop, short, long,
        output w1, w2, w3, running, cycle_end, cycle_cnt
    );
endinterface

// File: rtl/timing_beat_gen.sv
// W1/W2/W3 machine-cycle beat sequencer with QD start, single step and completed-cycle counter.
//   state | meaning
//   IDLE  | halted, waiting for a QD rising edge
//   B1    | beat 1 (final when short)
//   B2    | beat 2 (final unless long)
//   B3    | beat 3 (always final)
module timing_beat_gen #(
    parameter int CNT_W = 8
) (
    input  logic                t3,
    input  logic                clr,
    timing_beat_gen_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        B1   = 2'd1,
        B2   = 2'd2,
        B3   = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             qd_q;
    logic             final_beat;
    logic             w1_q;
    logic             w2_q;
    logic             w3_q;
    logic             running_q;
    logic [CNT_W-1:0] cycle_cnt_q;

    always_comb begin
        state_d    = state_q;
        final_beat = 1'b0;
        case (state_q)
            IDLE: if (bus.qd && !qd_q) state_d = B1;
            B1:   if (bus.short) final_beat = 1'b1;
                  else           state_d    = B2;
            B2:   if (bus.long)  state_d    = B3;
                  else           final_beat = 1'b1;
            B3:   final_beat = 1'b1;
            default: state_d = IDLE;
        endcase
        // Halt requests only take effect at the end of a machine cycle.
        if (final_beat) state_d = (bus.stop || bus.step) ? IDLE : B1;
    end

    always_ff @(posedge t3) begin
        if (clr) begin
            state_q     <= IDLE;
            qd_q        <= 1'b1;
            w1_q        <= 1'b0;
            w2_q        <= 1'b0;
            w3_q        <= 1'b0;
            running_q   <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            qd_q      <= bus.qd;
            w1_q      <= (state_d == B1);
            w2_q      <= (state_d == B2);
            w3_q      <= (state_d == B3);
            running_q <= (state_d != IDLE);
            if (final_beat) cycle_cnt_q <= cycle_cnt_q + 1'b1;
        end
    end

    assign bus.w1        = w1_q;
    assign bus.w2        = w2_q;
    assign bus.w3        = w3_q;
    assign bus.running   = running_q;
    assign bus.cycle_end = final_beat;
    assign bus.cycle_cnt = cycle_cnt_q;
endmodule
